regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port register file with per-register scoreboard for the pipelined CPU.
//  N asynchronous read ports, one synchronous write port, busy bits marking registers with an
//  in-flight result. Sits in the decode stage; busy outputs drive the hazard/stall unit.
// PARAMETERS
//  DATA_W   16  register width in bits
//  ADDR_W   4   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD   3   number of read ports (>=1)
//  R0_ZERO  0   1: register 0 reads 0, ignores writes and reservations
// PORTS
//  clk       in   1               rising-edge clock
//  rst       in   1               synchronous reset, active-high
//  wre       in   1               write enable
//  wa        in   ADDR_W          write address
//  wd        in   DATA_W          write data
//  rsv_en    in   1               reserve destination (set busy bit)
//  rsv_addr  in   ADDR_W          register to reserve
//  ra        in   NUM_RD*ADDR_W   read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//  rd        out  NUM_RD*DATA_W   read data, port i = rd[i*DATA_W +: DATA_W]
//  rd_busy   out  NUM_RD          busy bit of each read port's register
//  stall     out  1               OR of rd_busy
//  busy_cnt  out  ADDR_W+1        number of registers currently busy
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst); all state updates on clk rising edge.
//  - Reset: all registers <= 0, all busy bits <= 0, busy_cnt <= 0; rst overrides wre/rsv_en
//    in the same cycle. rst mid-operation discards every pending reservation.
//  - Read: combinational from ra; zero cycles latency. rd/rd_busy follow reset state the cycle after rst.
//  - Write: wre=1 -> reg[wa] <= wd at edge; busy[wa] <= 0 (write retires reservation).
//    Writing a non-busy register is legal; busy stays 0.
//  - Reserve: rsv_en=1 -> busy[rsv_addr] <= 1 at edge; reserving an already-busy register keeps 1.
//  - Simultaneous wre and rsv_en:
//    * different addresses: both take effect.
//    * same address: data written, busy ends 1 (new reservation wins over retirement).
//  - busy_cnt: registered, always equals popcount(busy); +1/-1/0 per cycle per above rules,
//    never over DEPTH, never under 0.
//  - R0_ZERO=1: rd of addr 0 = 0, rd_busy of addr 0 = 0; wre/rsv_en to addr 0 ignored.
//  - Multiple read ports may address the same register; each sees identical data/busy.
//  - No X on outputs after first reset; unknown ra yields X only on that port.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - port i with wre=1 and ra_i==wa (and not R0 under R0_ZERO) returns wd combinationally
//      and rd_busy_i = 0 in that cycle, unless rsv_en=1 with rsv_addr==wa
//      (then rd_busy_i = 1, rd = wd).
//    - stall computed from bypassed rd_busy.
//  REGFILE_BYPASS_EN undefined:
//    - rd returns stored value; new data and cleared busy visible the cycle after the write edge.
// TESTING
//  1. rst=1 one cycle after writing 0xBEEF to r5 -> rd(r5)=0x0000, rd_busy=0, busy_cnt=0.
//  2. wre=1 wa=11 wd=0x0008, ra={11,9,7} -> next cycle rd0=0x0008; r9,r7 unchanged.
//  3. rsv_en r7; two cycles later wre r7=0x1234 -> rd_busy2=1, stall=1 between; busy_cnt 1->0.
//  4. Same cycle rsv_en r3 and wre r3=0x00AA -> rd(r3)=0x00AA, rd_busy=1, busy_cnt=1.
//  5. BYPASS_EN: wre r9=0x5A5A, ra1=9 same cycle -> rd1=0x5A5A, rd_busy1=0; undefined -> old value.
//  6. R0_ZERO=1: wre r0=0xFFFF, rsv_en r0 -> rd(r0)=0, rd_busy=0, busy_cnt unchanged.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard for the decode stage.
// N combinational read ports, one synchronous write port, and a busy bit per register.
// A reservation sets the busy bit and a write retires it. The stall output and
// busy_cnt feed the hazard unit.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to readers.
module regfile_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_RD  = 3,
  parameter int unsigned R0_ZERO = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wre,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       stall,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_eff, rsv_eff;
  logic [ADDR_W-1:0] port_addr [NUM_RD];

  // Under R0_ZERO, register 0 ignores writes and reservations.
  always_comb begin
    wr_eff  = wre    && !((R0_ZERO != 0) && (wa == '0));
    rsv_eff = rsv_en && !((R0_ZERO != 0) && (rsv_addr == '0));
  end

  // Next busy vector: a write clears the bit first, so a same-address reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_eff) begin
      busy_d[wa] = 1'b0;
    end
    if (rsv_eff) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Count is taken from the next busy vector, so it always matches the stored bits.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Register storage; reset clears every entry and overrides a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_eff) begin
      mem_q[wa] <= wd;
    end
  end

  // Scoreboard state; reset drops every pending reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports, with optional forwarding of the write in flight.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      port_addr[i]                = ra[i*ADDR_W +: ADDR_W];
      rd[i*DATA_W +: DATA_W]      = mem_q[port_addr[i]];
      rd_busy[i]                  = busy_q[port_addr[i]];
`ifdef REGFILE_BYPASS_EN
      if (wr_eff && (port_addr[i] == wa)) begin
        rd[i*DATA_W +: DATA_W] = wd;
        rd_busy[i]             = rsv_eff && (rsv_addr == wa);
      end
`endif
      if ((R0_ZERO != 0) && (port_addr[i] == '0)) begin
        rd[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]             = 1'b0;
      end
    end
  end

  // Hazard outputs.
  always_comb begin
    stall    = |rd_busy;
    busy_cnt = cnt_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations are queued as stimulus is applied and
// compared once the DUT outputs are valid. A second instance runs with R0_ZERO=1.
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 3;

  logic               clk = 1'b0;
  logic               rst, wre, rsv_en;
  logic [AW-1:0]      wa, rsv_addr;
  logic [DW-1:0]      wd;
  logic [NR*AW-1:0]   ra;
  logic [NR*DW-1:0]   rd, rd_z;
  logic [NR-1:0]      rd_busy, rd_busy_z;
  logic               stall, stall_z;
  logic [AW:0]        busy_cnt, busy_cnt_z;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .R0_ZERO(0)) u_dut (
    .clk(clk), .rst(rst), .wre(wre), .wa(wa), .wd(wd), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .ra(ra), .rd(rd), .rd_busy(rd_busy), .stall(stall),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .R0_ZERO(1)) u_dut_z (
    .clk(clk), .rst(rst), .wre(wre), .wa(wa), .wd(wd), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .ra(ra), .rd(rd_z), .rd_busy(rd_busy_z), .stall(stall_z),
    .busy_cnt(busy_cnt_z)
  );

  always #5 clk = ~clk;

  // Observation kinds.
  localparam int KRd = 0, KBusy = 1, KStall = 2, KCnt = 3;
  localparam int KRdZ = 4, KBusyZ = 5, KCntZ = 6, KStallZ = 7;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input int kind, input int idx,
                            input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      KRd:     return 32'(rd[idx*DW +: DW]);
      KBusy:   return 32'(rd_busy[idx]);
      KStall:  return 32'(stall);
      KCnt:    return 32'(busy_cnt);
      KRdZ:    return 32'(rd_z[idx*DW +: DW]);
      KBusyZ:  return 32'(rd_busy_z[idx]);
      KCntZ:   return 32'(busy_cnt_z);
      KStallZ: return 32'(stall_z);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.kind, e.idx);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    ra = {a2, a1, a0};
  endtask

  initial begin
    rst = 1'b1; wre = 1'b0; rsv_en = 1'b0; wa = '0; rsv_addr = '0; wd = '0;
    set_ra(0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    expect_val("reset_rd0", KRd, 0, 0);
    expect_val("reset_busy0", KBusy, 0, 0);
    expect_val("reset_stall", KStall, 0, 0);
    expect_val("reset_cnt", KCnt, 0, 0);
    check_all();

    // 1. Reset wipes a written register and overrides same-cycle write/reserve.
    wre = 1'b1; wa = 4'd5; wd = 16'hBEEF;
    tick();
    wre = 1'b0;
    set_ra(5, 6, 0);
    #1;
    expect_val("t1_pre_rd", KRd, 0, 16'hBEEF);
    check_all();
    rst = 1'b1; wre = 1'b1; wa = 4'd6; wd = 16'h1111; rsv_en = 1'b1; rsv_addr = 4'd6;
    tick();
    rst = 1'b0; wre = 1'b0; rsv_en = 1'b0;
    #1;
    expect_val("t1_rd_r5", KRd, 0, 0);
    expect_val("t1_busy_r5", KBusy, 0, 0);
    expect_val("t1_rd_r6", KRd, 1, 0);
    expect_val("t1_busy_r6", KBusy, 1, 0);
    expect_val("t1_cnt", KCnt, 0, 0);
    check_all();

    // 2. Write r11 while other ports watch r9/r7.
    wre = 1'b1; wa = 4'd9; wd = 16'h0009;
    tick();
    wa = 4'd7; wd = 16'h0007;
    tick();
    wa = 4'd11; wd = 16'h0008;
    set_ra(11, 9, 7);
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_val("t2_pre_rd0", KRd, 0, 16'h0008);
`else
    expect_val("t2_pre_rd0", KRd, 0, 16'h0000);
`endif
    check_all();
    tick();
    wre = 1'b0;
    #1;
    expect_val("t2_rd0", KRd, 0, 16'h0008);
    expect_val("t2_rd1", KRd, 1, 16'h0009);
    expect_val("t2_rd2", KRd, 2, 16'h0007);
    check_all();

    // 3. Reserve r7, retire it two cycles later.
    rsv_en = 1'b1; rsv_addr = 4'd7;
    tick();
    rsv_en = 1'b0;
    #1;
    expect_val("t3_busy2_c1", KBusy, 2, 1);
    expect_val("t3_stall_c1", KStall, 0, 1);
    expect_val("t3_cnt_c1", KCnt, 0, 1);
    check_all();
    tick();
    expect_val("t3_busy2_c2", KBusy, 2, 1);
    expect_val("t3_stall_c2", KStall, 0, 1);
    check_all();
    wre = 1'b1; wa = 4'd7; wd = 16'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_val("t3_wr_busy2", KBusy, 2, 0);
    expect_val("t3_wr_rd2", KRd, 2, 16'h1234);
`else
    expect_val("t3_wr_busy2", KBusy, 2, 1);
    expect_val("t3_wr_rd2", KRd, 2, 16'h0007);
`endif
    check_all();
    tick();
    wre = 1'b0;
    #1;
    expect_val("t3_rd2", KRd, 2, 16'h1234);
    expect_val("t3_busy2", KBusy, 2, 0);
    expect_val("t3_stall", KStall, 0, 0);
    expect_val("t3_cnt", KCnt, 0, 0);
    check_all();

    // 4. Same-address reserve and write: data lands, reservation survives.
    wre = 1'b1; wa = 4'd3; wd = 16'h00AA; rsv_en = 1'b1; rsv_addr = 4'd3;
    tick();
    wre = 1'b0; rsv_en = 1'b0;
    set_ra(3, 3, 3);
    #1;
    for (int p = 0; p < NR; p++) begin
      expect_val($sformatf("t4_rd%0d", p), KRd, p, 16'h00AA);
      expect_val($sformatf("t4_busy%0d", p), KBusy, p, 1);
    end
    expect_val("t4_cnt", KCnt, 0, 1);
    check_all();

    // Re-reserving a busy register leaves the count alone.
    rsv_en = 1'b1; rsv_addr = 4'd3;
    tick();
    #1;
    expect_val("rsv_again_cnt", KCnt, 0, 1);
    check_all();
    // Different addresses: r3 retires, r4 reserved.
    rsv_addr = 4'd4; wre = 1'b1; wa = 4'd3; wd = 16'h0033;
    set_ra(3, 4, 8);
    tick();
    rsv_en = 1'b0; wa = 4'd8; wd = 16'h0088;
    #1;
    expect_val("diff_busy_r3", KBusy, 0, 0);
    expect_val("diff_busy_r4", KBusy, 1, 1);
    expect_val("diff_rd_r3", KRd, 0, 16'h0033);
    expect_val("diff_cnt", KCnt, 0, 1);
    check_all();
    // Writing a non-busy register keeps it idle.
    tick();
    wre = 1'b0;
    #1;
    expect_val("nb_busy_r8", KBusy, 2, 0);
    expect_val("nb_rd_r8", KRd, 2, 16'h0088);
    expect_val("nb_cnt", KCnt, 0, 1);
    check_all();

    // Reserve every register: count saturates at DEPTH (DEPTH-1 with r0 hardwired).
    for (int i = 0; i < 16; i++) begin
      rsv_en = 1'b1; rsv_addr = 4'(i);
      tick();
    end
    rsv_en = 1'b0;
    #1;
    expect_val("full_cnt", KCnt, 0, 16);
    expect_val("full_cnt_z", KCntZ, 0, 15);
    expect_val("full_stall", KStall, 0, 1);
    check_all();

    // Reset mid-operation drops all reservations.
    rst = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd2;
    tick();
    rst = 1'b0; rsv_en = 1'b0;
    #1;
    expect_val("midrst_cnt", KCnt, 0, 0);
    expect_val("midrst_cnt_z", KCntZ, 0, 0);
    expect_val("midrst_stall", KStall, 0, 0);
    check_all();

    // 5. Read of a register written in the same cycle.
    wre = 1'b1; wa = 4'd9; wd = 16'h5A5A;
    set_ra(0, 9, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_val("t5_rd1", KRd, 1, 16'h5A5A);
`else
    expect_val("t5_rd1", KRd, 1, 16'h0000);
`endif
    expect_val("t5_busy1", KBusy, 1, 0);
    check_all();
    tick();
    wre = 1'b0;
    #1;
    expect_val("t5_post_rd1", KRd, 1, 16'h5A5A);
    check_all();

    // 6. Register 0 with R0_ZERO=1 ignores write and reservation; default instance does not.
    wre = 1'b1; wa = 4'd0; wd = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 4'd0;
    set_ra(0, 0, 0);
    #1;
    expect_val("t6_pre_rd_z", KRdZ, 0, 0);
    check_all();
    tick();
    wre = 1'b0; rsv_en = 1'b0;
    #1;
    expect_val("t6_rd_z", KRdZ, 0, 0);
    expect_val("t6_busy_z", KBusyZ, 0, 0);
    expect_val("t6_cnt_z", KCntZ, 0, 0);
    expect_val("t6_stall_z", KStallZ, 0, 0);
    expect_val("t6_rd", KRd, 0, 16'hFFFF);
    expect_val("t6_busy", KBusy, 0, 1);
    expect_val("t6_cnt", KCnt, 0, 1);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
